// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 8-bit ALU between NREQ requesters with a programmable settle time.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int ALU_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        alu_op1,
  output logic [7:0]        alu_op2,
  output logic [2:0]        alu_sel,
  input  logic [7:0]        alu_result,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_data,
  output logic [2:0]        resp_id,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next;
  logic [2:0] ptr, win, idx;
  logic [3:0] cnt;
  logic       any;
  logic [7:0] rv;
  logic [2:0] op_v [8];
  logic [7:0] a_v [8];
  logic [7:0] b_v [8];
  // Pad the request vectors to 8 entries so the winner index selects cleanly.
  for (genvar i = 0; i < 8; i++) begin : g_v
    if (i < NREQ) begin : g_r
      assign op_v[i] = req_op[3*i +: 3];
      assign a_v[i]  = req_a[8*i +: 8];
      assign b_v[i]  = req_b[8*i +: 8];
    end else begin : g_z
      assign op_v[i] = '0;
      assign a_v[i]  = '0;
      assign b_v[i]  = '0;
    end
  end
  assign rv = 8'(req_valid);
  // Scan from the far end back towards ptr so the nearest valid requester wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = 3'((int'(ptr) + k) % NREQ);
      if (rv[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end
  assign req_ready = (reset_n && state == IDLE && any) ? NREQ'(1) << win : '0;
  assign busy = (state != IDLE);
  always_comb begin
    next = (state == IDLE) ? (any ? EXEC : IDLE) :
           (state == EXEC) ? (cnt == 4'd1 ? RESP : EXEC) :
           (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_sel    <= '0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_valid <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && any) begin
        alu_sel <= op_v[win];
        alu_op1 <= a_v[win];
        alu_op2 <= b_v[win];
        resp_id <= win;
        cnt     <= 4'(ALU_WAIT);
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          resp_data  <= alu_result;
          resp_valid <= 1'b1;
        end
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        ptr        <= (resp_id == 3'(NREQ - 1)) ? '0 : resp_id + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: transaction-level model plus directed vectors for the ALU arbiter.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int ALU_WAIT = 4;
  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_op = '0;
  logic [8*NREQ-1:0] req_a = '0;
  logic [8*NREQ-1:0] req_b = '0;
  logic [7:0]        alu_op1, alu_op2, alu_result, resp_data;
  logic [2:0]        alu_sel, resp_id;
  logic              resp_valid, busy;
  logic              resp_ready = 1'b1;
  int total = 0;
  int bad = 0;

  alu_arbiter #(.NREQ(NREQ), .ALU_WAIT(ALU_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sel(alu_sel), .alu_result(alu_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    return (s == 3'd0) ? b : (s == 3'd1) ? a + b : (s == 3'd2) ? (a & b) : (s == 3'd3) ? (a | b) : 8'd0;
  endfunction

  function automatic int rr(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  assign alu_result = alu_f(alu_sel, alu_op1, alu_op2);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Transaction-level model: idle -> result due ALU_WAIT cycles after accept -> held until consumed.
  bit         m_idle = 1'b1;
  bit         m_rv = 1'b0;
  int         m_ptr = 0;
  int         m_id = 0;
  int         m_age = 0;
  logic [7:0] m_res = '0, m_data = '0, m_a = '0, m_b = '0;
  logic [2:0] m_sel = '0;
  int         m_win;
  assign m_win = rr(m_ptr, req_valid);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_idle <= 1'b1; m_rv <= 1'b0; m_ptr <= 0; m_id <= 0; m_age <= 0;
      m_res <= '0; m_data <= '0; m_a <= '0; m_b <= '0; m_sel <= '0;
    end else if (m_idle) begin
      if (m_win >= 0) begin
        m_idle <= 1'b0;
        m_id   <= m_win;
        m_age  <= 0;
        m_sel  <= req_op[3*m_win +: 3];
        m_a    <= req_a[8*m_win +: 8];
        m_b    <= req_b[8*m_win +: 8];
        m_res  <= alu_f(req_op[3*m_win +: 3], req_a[8*m_win +: 8], req_b[8*m_win +: 8]);
      end
    end else if (!m_rv) begin
      m_age <= m_age + 1;
      if (m_age + 1 == ALU_WAIT) begin
        m_rv   <= 1'b1;
        m_data <= m_res;
      end
    end else if (resp_ready) begin
      m_rv   <= 1'b0;
      m_idle <= 1'b1;
      m_ptr  <= (m_id + 1) % NREQ;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), (reset_n && m_idle && m_win >= 0) ? 32'(1) << m_win : 32'd0);
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("resp_valid", 32'(resp_valid), 32'(m_rv));
    chk("resp_data", 32'(resp_data), 32'(m_data));
    chk("resp_id", 32'(resp_id), 32'(m_id));
    chk("alu_sel", 32'(alu_sel), 32'(m_sel));
    chk("alu_op1", 32'(alu_op1), 32'(m_a));
    chk("alu_op2", 32'(alu_op2), 32'(m_b));
  end

  task automatic wait_idle();
    bit got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      got = !busy;
    end
    chk("idle_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_op(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp);
    int lat = 0;
    bit got = 1'b0;
    req_op[3*id +: 3] = op;
    req_a[8*id +: 8] = a;
    req_b[8*id +: 8] = b;
    req_valid[id] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = req_ready[id];
    end
    chk("grant_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(posedge clk);
      #1 lat++;
      got = resp_valid;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("op_data", 32'(resp_data), 32'(exp));
    chk("op_id", 32'(resp_id), 32'(id));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int grants [6];
    int n, idle_cnt;
    bit got;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    reset_n = 1'b1;
    do_op(0, 3'b000, 8'd0, 8'd65, 8'd65);
    do_op(2, 3'b001, 8'd45, 8'd30, 8'd75);
    do_op(2, 3'b001, 8'd100, 8'd100, 8'hC8);
    chk("add_signed", 32'($signed(resp_data)), 32'(-56));
    do_op(1, 3'b010, 8'h26, 8'h3A, 8'h22);
    do_op(1, 3'b011, 8'h26, 8'h3A, 8'h3E);
    do_op(1, 3'b101, 8'h26, 8'h3A, 8'h00);
    // Fairness: all requesters valid from reset.
    @(posedge clk);
    #1 reset_n = 1'b0;
    req_valid = 4'hF;
    @(posedge clk);
    #1 reset_n = 1'b1;
    n = 0;
    idle_cnt = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("onehot", 32'($countones(req_ready)), 32'd1);
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) grants[n] = k;
        n++;
      end
      if (!busy && n >= 1) idle_cnt++;
    end
    chk("grant_count", 32'(n), 32'd6);
    chk("grant0", 32'(grants[0]), 32'd0);
    chk("grant1", 32'(grants[1]), 32'd1);
    chk("grant2", 32'(grants[2]), 32'd2);
    chk("grant3", 32'(grants[3]), 32'd3);
    chk("grant4", 32'(grants[4]), 32'd0);
    chk("grant5", 32'(grants[5]), 32'd1);
    chk("idle_gaps", 32'(idle_cnt), 32'd6);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    // Backpressure with requester 1 as owner; others queue up meanwhile.
    @(posedge clk);
    #1 resp_ready = 1'b0;
    req_op[5:3] = 3'b001;
    req_a[15:8] = 8'd3;
    req_b[15:8] = 8'd4;
    req_valid = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = req_ready[1];
    end
    chk("bp_grant", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid = 4'b1101;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = resp_valid;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'd7);
      chk("bp_id", 32'(resp_id), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    // Reset during the second EXEC cycle of requester 2.
    @(posedge clk);
    #1 req_valid = 4'b0100;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      got = req_ready[2];
    end
    chk("mr_grant", 32'(got), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd0);
    chk("mr_valid", 32'(resp_valid), 32'd0);
    chk("mr_data", 32'(resp_data), 32'd0);
    chk("mr_op1", 32'(alu_op1), 32'd0);
    chk("mr_id", 32'(resp_id), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("mr_first", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
